letc_core_stage_memory1: RTL

LETC_CORE_STAGE_MEMORY1 -- requirements
Module: letc_core_stage_memory1

---
 rtl/letc_core_pkg.sv | 53 +++++
 rtl/letc_core_lsu_align.sv | 40 ++++
 rtl/letc_core_stage_memory1.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/letc_core_pkg.sv
// Shared types for the LETC core pipeline.
//   mem_op_e / mem_size_e : memory operation kind and access width
//   e_to_m1_s             : execute -> memory1 stage payload
//   m1_to_m2_s            : memory1 -> memory2 stage payload (adds misalignment flags)
//   base_strb()           : unshifted byte-strobe pattern for an access width
package letc_core_pkg;

    typedef enum logic [1:0] {
        MEM_OP_NOP,
        MEM_OP_LOAD,
        MEM_OP_STORE,
        MEM_OP_AMO
    } mem_op_e;

    typedef enum logic [1:0] {
        MEM_SIZE_BYTE,
        MEM_SIZE_HALF,
        MEM_SIZE_WORD
    } mem_size_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd_idx;
        logic        rd_we;
        logic [31:0] alu_result;
        logic [31:0] rs2_val;
        mem_op_e     mem_op;
        mem_size_e   mem_size;
        logic        mem_signed;
    } e_to_m1_s;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd_idx;
        logic        rd_we;
        logic [31:0] alu_result;
        logic [31:0] rs2_val;
        mem_op_e     mem_op;
        mem_size_e   mem_size;
        logic        mem_signed;
        logic        ld_misaligned;
        logic        st_misaligned;
    } m1_to_m2_s;

    function automatic logic [3:0] base_strb(mem_size_e size);
        case (size)
            MEM_SIZE_BYTE: base_strb = 4'b0001;
            MEM_SIZE_HALF: base_strb = 4'b0011;
            default:       base_strb = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/letc_core_lsu_align.sv
// Combinational load/store alignment helper.
//   addr_lo_i    : low two bits of the byte address
//   mem_op_i     : memory operation (NOP never reports misalignment)
//   mem_size_i   : access width (ignored for AMO, which is always a word)
//   rs2_val_i    : store data before lane shifting
//   misaligned_o : access does not sit on its natural boundary
//   wstrb_o      : byte strobes, zero for anything that is not a store
//   wdata_o      : store data shifted into its byte lane
module letc_core_lsu_align
    import letc_core_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  mem_op_e     mem_op_i,
    input  mem_size_e   mem_size_i,
    input  logic [31:0] rs2_val_i,
    output logic        misaligned_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o
);

    mem_size_e eff_size;

    always_comb begin
        eff_size = (mem_op_i == MEM_OP_AMO) ? MEM_SIZE_WORD : mem_size_i;

        misaligned_o = 1'b0;
        case (eff_size)
            MEM_SIZE_HALF: misaligned_o = addr_lo_i[0];
            MEM_SIZE_WORD: misaligned_o = |addr_lo_i;
            default:       misaligned_o = 1'b0;
        endcase
        if (mem_op_i == MEM_OP_NOP) begin
            misaligned_o = 1'b0;
        end

        wdata_o = rs2_val_i << {addr_lo_i, 3'b000};
        wstrb_o = (mem_op_i == MEM_OP_STORE) ? (base_strb(eff_size) << addr_lo_i) : 4'b0000;
    end

endmodule

// File: rtl/letc_core_stage_memory1.sv
// LETC core memory stage 1: issues data-memory requests and forwards to M2.
//   clk, rst_n          : clock (rising edge) and asynchronous active-low reset
//   m1_ready            : stage can accept a new instruction this cycle
//   m1_flush / m1_stall : kill / hold the instruction held in M1
//   e_to_m1_valid/_to_m1: upstream instruction and payload
//   m1_to_m2_valid/_to_m2: downstream instruction and payload
//   dmem_req_*          : data-memory request channel (valid/ready handshake)
module letc_core_stage_memory1
    import letc_core_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        m1_ready,
    input  logic        m1_flush,
    input  logic        m1_stall,
    input  logic        e_to_m1_valid,
    input  e_to_m1_s    e_to_m1,
    output logic        m1_to_m2_valid,
    output m1_to_m2_s   m1_to_m2,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [31:0] dmem_req_addr,
    output logic        dmem_req_we,
    output logic [31:0] dmem_req_wdata,
    output logic [3:0]  dmem_req_wstrb
);

    // StWait: request presented, not accepted. StHeld: accepted, output stalled.
    // StDrain: flushed while the request is still outstanding.
    typedef enum logic [1:0] {StIdle, StWait, StHeld, StDrain} state_e;

    state_e    state_q, state_d;
    logic      valid_q, valid_d;
    e_to_m1_s  payload_q;
    logic      capture;
    logic      clear_valid;
    logic      mem_instr;
    logic      misaligned;
    logic      aligned_mem;

    letc_core_lsu_align u_align (
        .addr_lo_i    (payload_q.alu_result[1:0]),
        .mem_op_i     (payload_q.mem_op),
        .mem_size_i   (payload_q.mem_size),
        .rs2_val_i    (payload_q.rs2_val),
        .misaligned_o (misaligned),
        .wstrb_o      (dmem_req_wstrb),
        .wdata_o      (dmem_req_wdata)
    );

    assign capture       = !m1_stall && m1_ready;
    assign mem_instr     = valid_q && (payload_q.mem_op != MEM_OP_NOP);
    assign aligned_mem   = mem_instr && !misaligned;
    // Request fields come straight from the payload flop, so they stay stable
    // for as long as the stage refuses new input (WAIT/DRAIN).
    assign dmem_req_addr = payload_q.alu_result;
    assign dmem_req_we   = (payload_q.mem_op == MEM_OP_STORE);

    always_comb begin
        state_d        = state_q;
        dmem_req_valid = 1'b0;
        m1_to_m2_valid = 1'b0;
        m1_ready       = 1'b1;
        clear_valid    = 1'b0;
        unique case (state_q)
            StIdle: begin
                clear_valid = m1_flush;
                if (aligned_mem && !m1_stall && !m1_flush) begin
                    dmem_req_valid = 1'b1;
                    if (dmem_req_ready) begin
                        m1_to_m2_valid = 1'b1;
                    end else begin
                        m1_ready = 1'b0;
                        state_d  = StWait;
                    end
                end else if (valid_q && !aligned_mem) begin
                    // Non-memory or misaligned: pass through, no request.
                    m1_to_m2_valid = !m1_stall && !m1_flush;
                end
            end
            StWait: begin
                m1_ready       = 1'b0;
                dmem_req_valid = 1'b1;
                if (dmem_req_ready) begin
                    if (m1_flush) begin
                        // Accepted and killed together: nothing left to drain.
                        state_d     = StIdle;
                        clear_valid = 1'b1;
                    end else if (m1_stall) begin
                        state_d = StHeld;
                    end else begin
                        m1_to_m2_valid = 1'b1;
                        state_d        = StIdle;
                        clear_valid    = 1'b1;
                    end
                end else if (m1_flush) begin
                    state_d     = StDrain;
                    clear_valid = 1'b1;
                end
            end
            StHeld: begin
                if (m1_flush) begin
                    state_d     = StIdle;
                    clear_valid = 1'b1;
                end else if (!m1_stall) begin
                    m1_to_m2_valid = 1'b1;
                    state_d        = StIdle;
                    clear_valid    = 1'b1;
                end
            end
            StDrain: begin
                m1_ready       = 1'b0;
                dmem_req_valid = 1'b1;
                if (dmem_req_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        if (capture) begin
            valid_d = e_to_m1_valid;
        end else if (clear_valid) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    always_comb begin
        m1_to_m2.pc            = payload_q.pc;
        m1_to_m2.rd_idx        = payload_q.rd_idx;
        m1_to_m2.rd_we         = payload_q.rd_we;
        m1_to_m2.alu_result    = payload_q.alu_result;
        m1_to_m2.rs2_val       = payload_q.rs2_val;
        m1_to_m2.mem_op        = payload_q.mem_op;
        m1_to_m2.mem_size      = payload_q.mem_size;
        m1_to_m2.mem_signed    = payload_q.mem_signed;
        m1_to_m2.ld_misaligned = mem_instr && misaligned && (payload_q.mem_op != MEM_OP_STORE);
        m1_to_m2.st_misaligned = mem_instr && misaligned && (payload_q.mem_op == MEM_OP_STORE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end

    // Payload carries no reset; valid_q qualifies it.
    always_ff @(posedge clk) begin
        if (capture) begin
            payload_q <= e_to_m1;
        end
    end

endmodule
